fsic_is_rx_fifo: RTL

- Receive-side buffer directly downstream of the IO serdes.
- Captures the unthrottled is_as_* beat stream recovered from the serial link into a FIFO.
- Presents it as a standard AXI-Stream master (with tready) to the local axis switch.
- Generates the local flow-control bit fc_tready, fed back into the serdes as_is_tready input. This tells the remote side to stop sending before the FIFO can overflow.

---
 rtl/fsic_axis_pkg.sv | 13 +
 rtl/fsic_fifo_mem.sv | 22 ++
 rtl/fsic_is_rx_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/fsic_axis_pkg.sv
// fsic_axis_pkg: shared AXI-Stream sideband widths, entry packing width and flow-control default.
package fsic_axis_pkg;

    localparam int TID_W                = 2;
    localparam int TUSER_W              = 2;
    localparam int FC_THRESHOLD_DEFAULT = 3;

    // Stored entry is {tlast, tid, tuser, tkeep, tstrb, tdata}
    function automatic int entry_width(input int data_w);
        return data_w + 2 * (data_w / 8) + 1 + TID_W + TUSER_W;
    endfunction

endpackage

// File: rtl/fsic_fifo_mem.sv
// fsic_fifo_mem: unreset register array with one synchronous write port and one asynchronous read port.
module fsic_fifo_mem #(
    parameter int pWIDTH = 45,
    parameter int pDEPTH = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(pDEPTH)-1:0]  waddr,
    input  logic [pWIDTH-1:0]          wdata,
    input  logic [$clog2(pDEPTH)-1:0]  raddr,
    output logic [pWIDTH-1:0]          rdata
);

    logic [pWIDTH-1:0] mem_q [pDEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fsic_is_rx_fifo.sv
// fsic_is_rx_fifo: receive buffer behind the IO serdes; unthrottled beats in, AXI-Stream master out,
// with a registered flow-control bit back to the remote side and a sticky overflow flag.
module fsic_is_rx_fifo
    import fsic_axis_pkg::*;
#(
    parameter int pDATA_WIDTH   = 32,
    parameter int pDEPTH        = 8,
    parameter int pFC_THRESHOLD = FC_THRESHOLD_DEFAULT
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst,
    input  logic [pDATA_WIDTH-1:0]        s_tdata,
    input  logic [pDATA_WIDTH/8-1:0]      s_tstrb,
    input  logic [pDATA_WIDTH/8-1:0]      s_tkeep,
    input  logic                          s_tlast,
    input  logic [TID_W-1:0]              s_tid,
    input  logic [TUSER_W-1:0]            s_tuser,
    input  logic                          s_tvalid,
    output logic [pDATA_WIDTH-1:0]        m_tdata,
    output logic [pDATA_WIDTH/8-1:0]      m_tstrb,
    output logic [pDATA_WIDTH/8-1:0]      m_tkeep,
    output logic                          m_tlast,
    output logic [TID_W-1:0]              m_tid,
    output logic [TUSER_W-1:0]            m_tuser,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          fc_tready,
    output logic [$clog2(pDEPTH+1)-1:0]   level,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int EW = entry_width(pDATA_WIDTH);
    localparam int PW = $clog2(pDEPTH);
    localparam int LW = $clog2(pDEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] out_q, out_d, wr_entry, rd_entry;
    logic          m_tvalid_q, m_tvalid_d, fc_q, fc_d, ovf_q, ovf_d;
    logic          push, pop;

    assign wr_entry = {s_tlast, s_tid, s_tuser, s_tkeep, s_tstrb, s_tdata};

    fsic_fifo_mem #(
        .pWIDTH (EW),
        .pDEPTH (pDEPTH)
    ) u_mem (
        .clk   (axis_clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_d),
        .rdata (rd_entry)
    );

    // The output register shows mem[rd_ptr_d] whenever an older entry survives this cycle's pop,
    // which gives one cycle of fall-through latency and bubble-free back-to-back pops.
    always_comb begin
        pop        = m_tvalid_q && m_tready;
        push       = s_tvalid && (level_q < LW'(pDEPTH) || pop);
        wr_ptr_d   = !push ? wr_ptr_q : (wr_ptr_q == PW'(pDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d   = !pop ? rd_ptr_q : (rd_ptr_q == PW'(pDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        level_d    = level_q + LW'(push) - LW'(pop);
        m_tvalid_d = (level_q - LW'(pop)) != '0;
        out_d      = m_tvalid_d ? rd_entry : out_q;
        fc_d       = (pDEPTH - int'(level_d)) > pFC_THRESHOLD;
        ovf_d      = (s_tvalid && !push) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_q      <= '0;
            m_tvalid_q <= 1'b0;
            fc_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_q      <= out_d;
            m_tvalid_q <= m_tvalid_d;
            fc_q       <= fc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign {m_tlast, m_tid, m_tuser, m_tkeep, m_tstrb, m_tdata} = out_q;
    assign m_tvalid  = m_tvalid_q;
    assign fc_tready = fc_q;
    assign level     = level_q;
    assign ovf       = ovf_q;

endmodule
